bcd_serial_adder_ctrl: RTL and testbench

Digit-serial controller for multi-digit packed-BCD addition. It accepts two NDIGITS-wide BCD operands through a start/ready handshake and sequences one shared single-digit BCD adder across the digits, least significant digit first. It propagates the decimal carry between digits, flags non-BCD input digits, and presents the registered result with a one-cycle done pulse. It sits between a requester, such as a calculator front-end or display-update logic, and the combinational BCD digit datapath.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_add.sv | 30 +++
 rtl/bcd_serial_adder_ctrl.sv | 110 +++++++++++
 tb/tb_bcd_serial_adder_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD constants, controller state encoding and the decimal +6 correction.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int BCD_MAX     = 9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Adding 6 to the low nibble of a 10..19 binary digit sum yields the BCD digit.
    function automatic logic [3:0] bcd_correct(input logic [3:0] lo);
        return lo + BCD_CORR;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal correction and invalid-digit detection.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co,
    output logic       inv
);

    logic [4:0] t;

    always_comb begin
        t   = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        inv = (a > 4'(BCD_MAX)) || (b > 4'(BCD_MAX));
        s   = t[3:0];
        co  = 1'b0;
        // An invalid digit yields 4'hF and kills the carry so it cannot corrupt higher digits.
        if (inv) begin
            s  = 4'hF;
            co = 1'b0;
        end else if (t > 5'(BCD_MAX)) begin
            s  = bcd_correct(t[3:0]);
            co = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// Digit-serial packed-BCD adder: one shared digit adder sequenced LSD first over NDIGITS cycles.
module bcd_serial_adder_ctrl
    import bcd_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [BCD_DIGIT_W*NDIGITS-1:0] op_a,
    input  logic [BCD_DIGIT_W*NDIGITS-1:0] op_b,
    input  logic                           cin,
    output logic                           ready,
    output logic                           busy,
    output logic                           done,
    output logic [BCD_DIGIT_W*NDIGITS-1:0] sum,
    output logic                           cout,
    output logic                           err,
    output state_t                         dbg_state
);

    localparam int W    = BCD_DIGIT_W * NDIGITS;
    localparam int IDXW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIGITS - 1);

    // Handshake: a request is taken on the rising edge where start && ready; the
    // requester holds start until then, and results are valid from the done pulse on.
    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            carry_q;
    logic [IDXW-1:0] idx;

    logic [3:0] da;
    logic [3:0] db;
    logic [3:0] ds;
    logic       dco;
    logic       dinv;

    assign da        = a_q[BCD_DIGIT_W*idx +: BCD_DIGIT_W];
    assign db        = b_q[BCD_DIGIT_W*idx +: BCD_DIGIT_W];
    assign dbg_state = state;

    bcd_digit_add u_digit (
        .a   (da),
        .b   (db),
        .ci  (carry_q),
        .s   (ds),
        .co  (dco),
        .inv (dinv)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
            err     <= 1'b0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && ready) begin
                        a_q     <= op_a;
                        b_q     <= op_b;
                        carry_q <= cin;
                        idx     <= '0;
                        sum     <= '0;
                        cout    <= 1'b0;
                        err     <= 1'b0;
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ADD;
                    end
                end
                ADD: begin
                    sum[BCD_DIGIT_W*idx +: BCD_DIGIT_W] <= ds;
                    carry_q <= dco;
                    err     <= err | dinv;
                    if (idx == LAST_IDX) begin
                        cout  <= dco;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// Directed bench for bcd_serial_adder_ctrl (NDIGITS=4) with a result queue checked on every done pulse.
module tb_bcd_serial_adder_ctrl;
    import bcd_pkg::*;

    localparam int ND = 4;
    localparam int W  = 4 * ND;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    state_t       dbg_state;

    int total = 0;
    int bad   = 0;
    logic [W+1:0] exp_q[$];   // {cout, err, sum}

    bcd_serial_adder_ctrl #(.NDIGITS(ND)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // scoreboard: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            check("done_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                check("result", 32'({cout, err, sum}), 32'(exp_q.pop_front()));
        end
    end

    // driver tasks (called at a negedge, return at a negedge)
    task automatic wait_done(input logic [W-1:0] exp_sum);
        int lat;
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'd5);
        check("busy_in_done", 32'(busy), 32'd1);
        check("ready_in_done", 32'(ready), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("ready_after", 32'(ready), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
        check("sum_held", 32'(sum), 32'(exp_sum));
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] exp_sum, input logic exp_cout, input logic exp_err);
        exp_q.push_back({exp_cout, exp_err, exp_sum});
        check("ready_before", 32'(ready), 32'd1);
        op_a  = a;
        op_b  = b;
        cin   = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op_a  = 16'($urandom);
        op_b  = 16'($urandom);
        cin   = 1'($urandom_range(0, 1));
        check("busy_first_add", 32'(busy), 32'd1);
        wait_done(exp_sum);
    endtask

    initial begin
        int cnt;
        int cyc;
        int last;

        rst_n = 1'b0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // basic additions and carry boundaries
        do_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        do_op(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        do_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0);

        // invalid digit, then a valid op clears err
        do_op(16'h00A0, 16'h0005, 1'b0, 16'h00F5, 1'b0, 1'b1);
        do_op(16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);

        // start pulsed during ADD is ignored
        exp_q.push_back({1'b0, 1'b0, 16'h6912});
        op_a  = 16'h1234;
        op_b  = 16'h5678;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_ready_c1", 32'(ready), 32'd0);
        @(negedge clk);
        check("ign_ready_c2", 32'(ready), 32'd0);
        start = 1'b1;
        op_a  = 16'h9999;
        op_b  = 16'h9999;
        cin   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_ready_c3", 32'(ready), 32'd0);
        @(negedge clk);
        check("ign_ready_c4", 32'(ready), 32'd0);
        @(negedge clk);
        check("ign_done", 32'(done), 32'd1);
        check("ign_sum", 32'(sum), 32'h6912);
        repeat (8) @(negedge clk);
        check("ign_queue_empty", 32'(exp_q.size()), 32'd0);

        // reset during the second ADD cycle discards the operation
        op_a  = 16'h1234;
        op_b  = 16'h5678;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_sum_digit0", 32'(sum), 32'h0002);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_ready", 32'(ready), 32'd1);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_sum", 32'(sum), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_state", 32'(dbg_state), 32'(IDLE));
        repeat (8) @(negedge clk);
        do_op(16'h0456, 16'h0789, 1'b0, 16'h1245, 1'b0, 1'b0);

        // start held high: back-to-back operations every 6 cycles
        repeat (3) exp_q.push_back({1'b1, 1'b0, 16'h0123});
        op_a  = 16'h4567;
        op_b  = 16'h5555;
        cin   = 1'b1;
        start = 1'b1;
        cnt   = 0;
        cyc   = 0;
        last  = 0;
        while (cnt < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                if (cnt > 0)
                    check("hold_spacing", 32'(cyc - last), 32'd6);
                last = cyc;
                cnt++;
            end
        end
        start = 1'b0;
        check("hold_done_count", 32'(cnt), 32'd3);
        check("hold_first_done", 32'(cyc - 12), 32'd5);
        repeat (10) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_ready", 32'(ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
